// File: rtl/program_loader_if.sv
// Byte-stream input and CPU memory-load output bundle of the program loader.
// The loader sits on the slave modport; the stream source / CPU side uses master.
interface program_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              cpu_rst;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              write_instruction;
  logic              write_data;
  logic              busy;
  logic              error;

  modport master (
    output in_data, in_valid,
    input  in_ready, cpu_rst, mem_addr, mem_data,
    input  write_instruction, write_data, busy, error
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, cpu_rst, mem_addr, mem_data,
    output write_instruction, write_data, busy, error
  );
endinterface

// File: rtl/program_loader.sv
// Parses a framed byte stream into big-endian 32-bit words and writes them into the
// CPU instruction or data memory, holding the CPU in reset while loading.
module program_loader #(
  parameter int         ADDR_W   = 10,
  parameter logic [7:0] CMD_INST = 8'h49,
  parameter logic [7:0] CMD_DATA = 8'h44,
  parameter logic [7:0] CMD_RUN  = 8'h52,
  parameter logic [7:0] CMD_HALT = 8'h48
) (
  input  logic            clk,
  input  logic            rst,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_A_HI, S_A_LO, S_C_HI, S_C_LO, S_BYTE, S_WRITE
  } state_t;

  state_t            state_r;
  logic [7:0]        hi_r;
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       cnt_r;
  logic [1:0]        idx_r;
  logic [23:0]       word_r;
  logic              tgt_inst_r;
  logic              cpu_rst_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_data_r;
  logic              wr_inst_r;
  logic              wr_data_r;
  logic              busy_r;
  logic              error_r;

  logic              in_ready_s;
  logic              xfer_s;
  logic [15:0]       pair_s;

  // Acceptance decode; the WRITE cycle is the only stall
  always_comb begin
    in_ready_s = (!rst) && (state_r != S_WRITE);
    xfer_s     = bus.in_valid && in_ready_s;
    pair_s     = {hi_r, bus.in_data};
  end

  // Frame parser, word assembler and memory write sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      hi_r       <= 8'h00;
      addr_r     <= '0;
      cnt_r      <= 16'h0000;
      idx_r      <= 2'd0;
      word_r     <= 24'h000000;
      tgt_inst_r <= 1'b0;
      cpu_rst_r  <= 1'b1;
      mem_addr_r <= '0;
      mem_data_r <= 32'h0000_0000;
      wr_inst_r  <= 1'b0;
      wr_data_r  <= 1'b0;
      busy_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      wr_inst_r <= 1'b0;
      wr_data_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (xfer_s) begin
            case (bus.in_data)
              CMD_INST, CMD_DATA: begin
                tgt_inst_r <= (bus.in_data == CMD_INST);
                cpu_rst_r  <= 1'b1;
                busy_r     <= 1'b1;
                state_r    <= S_A_HI;
              end
              CMD_RUN:  cpu_rst_r <= 1'b0;
              CMD_HALT: cpu_rst_r <= 1'b1;
              default:  error_r   <= 1'b1;
            endcase
          end
        end
        S_A_HI: begin
          if (xfer_s) begin
            hi_r    <= bus.in_data;
            state_r <= S_A_LO;
          end
        end
        S_A_LO: begin
          if (xfer_s) begin
            addr_r  <= pair_s[ADDR_W-1:0];
            state_r <= S_C_HI;
          end
        end
        S_C_HI: begin
          if (xfer_s) begin
            hi_r    <= bus.in_data;
            state_r <= S_C_LO;
          end
        end
        S_C_LO: begin
          if (xfer_s) begin
            cnt_r <= pair_s;
            idx_r <= 2'd0;
            if (pair_s == 16'h0000) begin
              busy_r  <= 1'b0;
              state_r <= S_IDLE;
            end else begin
              state_r <= S_BYTE;
            end
          end
        end
        S_BYTE: begin
          if (xfer_s) begin
            idx_r <= idx_r + 2'd1;
            if (idx_r == 2'd3) begin
              mem_data_r <= {word_r, bus.in_data};
              mem_addr_r <= addr_r;
              wr_inst_r  <= tgt_inst_r;
              wr_data_r  <= !tgt_inst_r;
              state_r    <= S_WRITE;
            end else begin
              word_r <= {word_r[15:0], bus.in_data};
            end
          end
        end
        S_WRITE: begin
          // Address wraps naturally at 2**ADDR_W
          addr_r <= addr_r + ADDR_W'(1);
          cnt_r  <= cnt_r - 16'd1;
          idx_r  <= 2'd0;
          if (cnt_r == 16'd1) begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            state_r <= S_BYTE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready          = in_ready_s;
  assign bus.cpu_rst           = cpu_rst_r;
  assign bus.mem_addr          = mem_addr_r;
  assign bus.mem_data          = mem_data_r;
  assign bus.write_instruction = wr_inst_r;
  assign bus.write_data        = wr_data_r;
  assign bus.busy              = busy_r;
  assign bus.error             = error_r;

endmodule
